// File: rtl/conv_window_ctrl.sv
// Binary conv sequencer: loads a KxK kernel and an IMG_H-row image, then issues each stride-1 window for CONV_LAT+1 cycles.
// Results are held on out_* until out_ready (1 result in flight); CONV_CTRL_THRESH_EN selects a 1-bit thresholded output.
module conv_window_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K        = 6,
  parameter int SUM_W    = 6,
  parameter int CONV_LAT = 1,
  parameter int THRESH   = 18,
  localparam int NR = IMG_H - K + 1,
  localparam int NC = IMG_W - K + 1,
  localparam int RW = (NR > 1) ? $clog2(NR) : 1,
  localparam int CW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             k_valid,
  output logic             k_ready,
  input  logic [K*K-1:0]   k_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [IMG_W-1:0] pix_data,
  output logic             conv_en,
  output logic [K*K-1:0]   conv_win,
  output logic [K*K-1:0]   conv_kernel,
  input  logic [SUM_W-1:0] conv_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_data,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             out_last
);

  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = $clog2(CONV_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_LOAD_IMG, S_ISSUE, S_OUTPUT} state_t;

  state_t           r_state;
  logic             r_busy, r_done, r_k_rdy, r_pix_rdy, r_conv_en;
  logic             r_out_vld, r_out_last;
  logic [SUM_W-1:0] r_out_dat;
  logic [RW-1:0]    r_out_row, r_row;
  logic [CW-1:0]    r_out_col, r_col;
  logic [K*K-1:0]   r_kernel;
  logic [YW-1:0]    r_y;
  logic [WW-1:0]    r_wait;
  logic [IMG_W-1:0] r_img [IMG_H];

  logic [K*K-1:0]   w_win;
  logic [K-1:0]     w_shift;
  logic [SUM_W-1:0] w_res;
  logic             w_final, w_col_wrap;

  // Window row i is image row r+i shifted down by c, keeping the low K columns.
  always_comb begin
    w_win   = '0;
    w_shift = '0;
    for (int i = 0; i < K; i++) begin
      w_shift          = K'(r_img[YW'(int'(r_row) + i)] >> r_col);
      w_win[i*K +: K]  = w_shift;
    end
  end

  assign w_col_wrap = (r_col == CW'(NC - 1));
  assign w_final    = w_col_wrap && (r_row == RW'(NR - 1));

`ifdef CONV_CTRL_THRESH_EN
  assign w_res = {{(SUM_W-1){1'b0}}, (int'(conv_sum) >= THRESH)};
`else
  assign w_res = conv_sum;
`endif

  // Image buffer survives reset on purpose; every run reloads all rows.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == S_LOAD_IMG && pix_valid)
      r_img[r_y] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_k_rdy    <= 1'b0;
      r_pix_rdy  <= 1'b0;
      r_conv_en  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_dat  <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_kernel   <= '0;
      r_y        <= '0;
      r_wait     <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_K;
            r_busy  <= 1'b1;
            r_k_rdy <= 1'b1;
          end
        end
        S_LOAD_K: begin
          if (k_valid) begin
            r_kernel  <= k_data;
            r_k_rdy   <= 1'b0;
            r_pix_rdy <= 1'b1;
            r_y       <= '0;
            r_state   <= S_LOAD_IMG;
          end
        end
        S_LOAD_IMG: begin
          if (pix_valid) begin
            r_y <= r_y + 1'b1;
            if (r_y == YW'(IMG_H - 1)) begin
              r_pix_rdy <= 1'b0;
              r_conv_en <= 1'b1;
              r_row     <= '0;
              r_col     <= '0;
              r_wait    <= '0;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_wait == WW'(CONV_LAT)) begin
            r_out_dat  <= w_res;
            r_out_row  <= r_row;
            r_out_col  <= r_col;
            r_out_last <= w_final;
            r_out_vld  <= 1'b1;
            r_conv_en  <= 1'b0;
            r_state    <= S_OUTPUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            if (r_out_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
              r_wait    <= '0;
              r_conv_en <= 1'b1;
              r_state   <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign k_ready     = r_k_rdy;
  assign pix_ready   = r_pix_rdy;
  assign conv_en     = r_conv_en;
  assign conv_kernel = r_kernel;
  assign conv_win    = (r_state == S_ISSUE || r_state == S_OUTPUT) ? w_win : '0;
  assign out_valid   = r_out_vld;
  assign out_data    = r_out_dat;
  assign out_row     = r_out_row;
  assign out_col     = r_out_col;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl with a 1-cycle popcount conv unit model.
module tb_conv_window_ctrl;
  localparam int IMG_W = 8, IMG_H = 8, K = 6, SUM_W = 6;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic             busy, done, k_ready, pix_ready, conv_en, out_valid, out_last;
  logic             k_valid = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
  logic [K*K-1:0]   k_data = '0, conv_win, conv_kernel;
  logic [IMG_W-1:0] pix_data = '0;
  logic [SUM_W-1:0] conv_sum = '0, out_data;
  logic [1:0]       out_row, out_col;

  int checks = 0, errors = 0, cyc = 0, load_cyc = 0;
  logic [7:0] img_buf [8];
  int res_dat [9], res_row [9], res_col [9], res_last [9], res_cyc [9];
  bit res_done, res_busy;
  int exp_bp [9] = '{15, 10, 6, 21, 15, 10, 26, 21, 15};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) conv_sum <= SUM_W'($countones(conv_win & conv_kernel));

  conv_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .conv_en(conv_en), .conv_win(conv_win), .conv_kernel(conv_kernel), .conv_sum(conv_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  function automatic int expv(input int s);
`ifdef CONV_CTRL_THRESH_EN
    return (s >= 18) ? 1 : 0;
`else
    return s;
`endif
  endfunction

  task automatic load(input logic [35:0] kern, input bit start_mid);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    k_valid = 1'b1; k_data = kern; @(posedge clk); #1; k_valid = 1'b0;
    for (int y = 0; y < 8; y++) begin
      pix_valid = 1'b1; pix_data = img_buf[y];
      start = start_mid && (y == 3);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; start = 1'b0;
    load_cyc = cyc;
  endtask

  // Captures up to 9 results; with hold>0 keeps out_ready low for hold cycles per result.
  task automatic collect(input int hold, output int n, output bit tmo, output bit unstable);
    int w;
    n = 0; tmo = 1'b0; unstable = 1'b0;
    out_ready = (hold == 0);
    while (n < 9) begin
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      if (!out_valid) begin tmo = 1'b1; break; end
      res_dat[n] = int'(out_data); res_row[n] = int'(out_row);
      res_col[n] = int'(out_col); res_last[n] = int'(out_last); res_cyc[n] = cyc;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!out_valid || int'(out_data) != res_dat[n] || int'(out_row) != res_row[n] ||
            int'(out_col) != res_col[n] || int'(out_last) != res_last[n]) unstable = 1'b1;
      end
      out_ready = 1'b1; @(posedge clk); #1;
      if (hold != 0) out_ready = 1'b0;
      n++;
    end
    res_done = done; res_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; repeat (3) @(posedge clk); #1;
    checks++; if ({busy, done, k_ready, pix_ready, conv_en, out_valid, out_last} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, want 0000000", {busy, done, k_ready, pix_ready, conv_en, out_valid, out_last}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, want 0", out_data); end
    checks++; if ({out_row, out_col} !== 4'b0) begin errors++; $display("FAIL reset_row_col: got %b, want 0000", {out_row, out_col}); end
    checks++; if (conv_win !== '0) begin errors++; $display("FAIL reset_conv_win: got %h, want 0", conv_win); end
    checks++; if (conv_kernel !== '0) begin errors++; $display("FAIL reset_conv_kernel: got %h, want 0", conv_kernel); end
    rst_n = 1'b1; @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || k_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b k_ready=%b, want 0 0", busy, k_ready); end
  endtask

  task automatic test_all_ones();
    int n; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'hFF;
    load({36{1'b1}}, 1'b0);
    checks++; if (k_ready !== 1'b0 || conv_en !== 1'b1) begin
      errors++; $display("FAIL ones_issue_entry: got k_ready=%b conv_en=%b, want 0 1", k_ready, conv_en); end
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL ones_count: got %0d, want 9", n); end
    checks++; if (n > 0 && res_cyc[0] - load_cyc != 2) begin
      errors++; $display("FAIL ones_first_latency: got %0d, want 2", res_cyc[0] - load_cyc); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != expv(36)) begin errors++; $display("FAIL ones_dat[%0d]: got %0d, want %0d", i, res_dat[i], expv(36)); end
      checks++; if (res_row[i] != i / 3 || res_col[i] != i % 3) begin
        errors++; $display("FAIL ones_pos[%0d]: got (%0d,%0d), want (%0d,%0d)", i, res_row[i], res_col[i], i / 3, i % 3); end
      checks++; if (res_last[i] != int'(i == 8)) begin errors++; $display("FAIL ones_last[%0d]: got %0d, want %0d", i, res_last[i], int'(i == 8)); end
      if (i > 0) begin
        checks++; if (res_cyc[i] - res_cyc[i-1] != 3) begin
          errors++; $display("FAIL ones_interval[%0d]: got %0d, want 3", i, res_cyc[i] - res_cyc[i-1]); end
      end
    end
    checks++; if (res_done !== 1'b1 || res_busy !== 1'b0) begin
      errors++; $display("FAIL ones_done: got done=%b busy=%b, want 1 0", res_done, res_busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ones_done_pulse: got done=%b out_valid=%b, want 0 0", done, out_valid); end
  endtask

  task automatic test_single_pixel();
    int n; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'h00;
    img_buf[7] = 8'h80;
    load({36{1'b1}}, 1'b0);
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL pix_count: got %0d, want 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != expv((i == 8) ? 1 : 0)) begin
        errors++; $display("FAIL pix_dat[%0d]: got %0d, want %0d", i, res_dat[i], expv((i == 8) ? 1 : 0)); end
    end
  endtask

  task automatic test_backpressure();
    int n; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'((1 << y) - 1);
    load({36{1'b1}}, 1'b0);
    collect(5, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL bp_count: got %0d, want 9", n); end
    checks++; if (uns) begin errors++; $display("FAIL bp_stable: got unstable=1, want 0"); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != expv(exp_bp[i]) || res_row[i] != i / 3 || res_col[i] != i % 3) begin
        errors++; $display("FAIL bp_res[%0d]: got %0d@(%0d,%0d), want %0d@(%0d,%0d)", i, res_dat[i], res_row[i], res_col[i],
                           expv(exp_bp[i]), i / 3, i % 3); end
    end
    checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b, want 1", res_done); end
  endtask

  task automatic test_start_while_busy();
    int n, w; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'hFF;
    out_ready = 1'b0;
    load({36{1'b1}}, 1'b1);
    checks++; if (k_ready !== 1'b0 || conv_en !== 1'b1) begin
      errors++; $display("FAIL sb_load: got k_ready=%b conv_en=%b, want 0 1", k_ready, conv_en); end
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    checks++; if (k_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sb_output: got k_ready=%b out_valid=%b, want 0 1", k_ready, out_valid); end
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL sb_count: got %0d, want 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != expv(36) || res_last[i] != int'(i == 8)) begin
        errors++; $display("FAIL sb_res[%0d]: got %0d last=%0d, want %0d last=%0d", i, res_dat[i], res_last[i], expv(36), int'(i == 8)); end
    end
    checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b, want 1", res_done); end
  endtask

  task automatic test_reset_mid();
    int n, w; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'((1 << y) - 1);
    out_ready = 1'b0;
    load({36{1'b1}}, 1'b0);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
      if (k < 3) begin out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0; end
    end
    checks++; if (out_valid !== 1'b1 || out_row !== 2'd1 || out_col !== 2'd0 || int'(out_data) != expv(21)) begin
      errors++; $display("FAIL rm_fourth: got v=%b %0d@(%0d,%0d), want v=1 %0d@(1,0)", out_valid, out_data, out_row, out_col, expv(21)); end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    checks++; if ({busy, done, k_ready, pix_ready, conv_en, out_valid, out_last} !== 7'b0) begin
      errors++; $display("FAIL rm_ctrl: got %b, want 0000000", {busy, done, k_ready, pix_ready, conv_en, out_valid, out_last}); end
    checks++; if (out_data !== '0 || {out_row, out_col} !== 4'b0 || conv_win !== '0 || conv_kernel !== '0) begin
      errors++; $display("FAIL rm_data: got dat=%0d rc=%b win=%h ker=%h, want all 0", out_data, {out_row, out_col}, conv_win, conv_kernel); end
    load({36{1'b1}}, 1'b0);
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL rm_count: got %0d, want 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != expv(exp_bp[i])) begin
        errors++; $display("FAIL rm_dat[%0d]: got %0d, want %0d", i, res_dat[i], expv(exp_bp[i])); end
    end
  endtask

`ifdef CONV_CTRL_THRESH_EN
  task automatic test_threshold();
    int n; bit tmo, uns;
    for (int y = 0; y < 8; y++) img_buf[y] = 8'hFF;
    load(36'h0_000F_FFFF, 1'b0);
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL th20_count: got %0d, want 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != 1) begin errors++; $display("FAIL th20_dat[%0d]: got %0d, want 1", i, res_dat[i]); end
    end
    load(36'h0_0001_FFFF, 1'b0);
    collect(0, n, tmo, uns);
    checks++; if (tmo || n != 9) begin errors++; $display("FAIL th17_count: got %0d, want 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (res_dat[i] != 0) begin errors++; $display("FAIL th17_dat[%0d]: got %0d, want 0", i, res_dat[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_single_pixel();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
`ifdef CONV_CTRL_THRESH_EN
    test_threshold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
